// File: rtl/fxp_div_scheduler.sv
// fxp_div_scheduler: round-robin front end that shares one iterative
// fixed-point long-division core between NUM_REQ requesters.
// Flow per request: accept (IDLE) -> start pulse (ISSUE) -> wait for core
// done (WAIT) -> tagged response (RESP).
// Optional build macro: FXP_DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor is answered directly with a saturated quotient and the core is
// never started.
module fxp_div_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int FRAC_W  = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_divisor,
  output logic                      o_div_start,
  output logic [DATA_W-1:0]         o_div_dividend,
  output logic [DATA_W-1:0]         o_div_divisor,
  input  logic                      i_div_done,
  input  logic [DATA_W-1:0]         i_div_quotient,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_quotient,
  output logic                      o_rsp_div_zero,
  input  logic                      i_rsp_ready,
  output logic                      o_busy
);

  // FRAC_W only describes how the core interprets the operands; the
  // scheduler moves the bits untouched, so it is used here only to reject
  // impossible configurations at elaboration time.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (FRAC_W > DATA_W)) begin : g_bad_cfg
    $error("fxp_div_scheduler: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_id;
  logic [DATA_W-1:0]    r_dividend;
  logic [DATA_W-1:0]    r_divisor;
  logic [DATA_W-1:0]    r_quotient;
  logic                 r_div_zero;
  logic                 w_found;
  logic [ID_W-1:0]      w_sel;
  logic [ID_W-1:0]      w_cand;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic                 w_div_start;
  logic                 w_divisor_zero;

  assign w_divisor_zero = (r_divisor == {DATA_W{1'b0}});

  // Round-robin search: walk from the highest offset down so the requester
  // closest to r_rr_ptr is the one left in w_sel.
  always_comb begin
    w_found = 1'b0;
    w_sel   = {ID_W{1'b0}};
    w_cand  = {ID_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end else begin
        w_sel   = w_sel;
      end
    end
  end

  // Next-state logic plus the combinational accept strobe and start pulse.
  always_comb begin
    w_next      = r_state;
    w_req_ready = {NUM_REQ{1'b0}};
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next             = S_ISSUE;
          w_req_ready[w_sel] = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifdef FXP_DIV_ZERO_BYPASS_EN
        if (w_divisor_zero) begin
          w_next = S_RESP;
        end else begin
          w_div_start = 1'b1;
          w_next      = S_WAIT;
        end
`else
        w_div_start = 1'b1;
        w_next      = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (i_div_done) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand/result capture and round-robin pointer update.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_ptr   <= {ID_W{1'b0}};
      r_id       <= {ID_W{1'b0}};
      r_dividend <= {DATA_W{1'b0}};
      r_divisor  <= {DATA_W{1'b0}};
      r_quotient <= {DATA_W{1'b0}};
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id       <= w_sel;
            r_dividend <= i_req_dividend[w_sel*DATA_W +: DATA_W];
            r_divisor  <= i_req_divisor[w_sel*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
`ifdef FXP_DIV_ZERO_BYPASS_EN
          if (w_divisor_zero) begin
            r_quotient <= {DATA_W{1'b1}};
            r_div_zero <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          if (i_div_done) begin
            r_quotient <= i_div_quotient;
            r_div_zero <= w_divisor_zero;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            if (r_id == ID_W'(NUM_REQ - 1)) begin
              r_rr_ptr <= {ID_W{1'b0}};
            end else begin
              r_rr_ptr <= r_id + 1'b1;
            end
          end
        end
        default: begin
          r_rr_ptr <= r_rr_ptr;
        end
      endcase
    end
  end

  assign o_req_ready    = w_req_ready;
  assign o_div_start    = w_div_start;
  assign o_div_dividend = r_dividend;
  assign o_div_divisor  = r_divisor;
  assign o_rsp_valid    = (r_state == S_RESP);
  assign o_rsp_id       = r_id;
  assign o_rsp_quotient = r_quotient;
  assign o_rsp_div_zero = r_div_zero;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fxp_div_scheduler.sv
// Self-checking bench for fxp_div_scheduler (NUM_REQ=2, DATA_W=8, FRAC_W=4).
// The bench plays the divider core and the response consumer, and predicts
// grants/quotients from a small behavioural model.
module tb_fxp_div_scheduler;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int FW = 4;
  localparam int IW = 1;
`ifdef FXP_DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N*DW-1:0] i_req_dividend;
  logic [N*DW-1:0] i_req_divisor;
  logic            o_div_start;
  logic [DW-1:0]   o_div_dividend;
  logic [DW-1:0]   o_div_divisor;
  logic            i_div_done;
  logic [DW-1:0]   i_div_quotient;
  logic            o_rsp_valid;
  logic [IW-1:0]   o_rsp_id;
  logic [DW-1:0]   o_rsp_quotient;
  logic            o_rsp_div_zero;
  logic            i_rsp_ready;
  logic            o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  logic [DW-1:0] dvd [N];
  logic [DW-1:0] dvs [N];

  fxp_div_scheduler #(.NUM_REQ(N), .DATA_W(DW), .FRAC_W(FW), .ID_W(IW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor),
    .o_div_start(o_div_start), .o_div_dividend(o_div_dividend),
    .o_div_divisor(o_div_divisor), .i_div_done(i_div_done),
    .i_div_quotient(i_div_quotient), .o_rsp_valid(o_rsp_valid),
    .o_rsp_id(o_rsp_id), .o_rsp_quotient(o_rsp_quotient),
    .o_rsp_div_zero(o_rsp_div_zero), .i_rsp_ready(i_rsp_ready),
    .o_busy(o_busy)
  );

  // Free-running clock, 10 time-unit period.
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference core: unsigned fixed-point divide, saturating; x/0 saturates.
  function automatic logic [DW-1:0] ref_quot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int q;
    if (b == 0) return {DW{1'b1}};
    q = (int'(a) << FW) / int'(b);
    if (q > 255) q = 255;
    return DW'(q);
  endfunction

  // Reference arbiter: first valid requester starting from the model pointer.
  function automatic int exp_grant(input logic [N-1:0] vld);
    for (int i = 0; i < N; i++) begin
      if (vld[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    i_req_dividend = {dvd[1], dvd[0]};
    i_req_divisor  = {dvs[1], dvs[0]};
  endtask

  // One complete request: accept, issue, core latency, backpressured response.
  task automatic do_txn(input logic [N-1:0] vld, input int lat, input int dly);
    int g;
    logic [DW-1:0] ed, es, eq;
    logic exp_start;
    g  = exp_grant(vld);
    ed = dvd[g];
    es = dvs[g];
    eq = ref_quot(ed, es);
    exp_start = !(BYPASS && (es == 0));
    drive_ops();
    i_req_valid = vld;
    #1;
    check_val("req_ready_grant", 32'(o_req_ready), 32'(1 << g));
    check_val("busy_idle", 32'(o_busy), 32'd0);
    step();
    check_val("start_issue", 32'(o_div_start), 32'(exp_start));
    check_val("div_dividend", 32'(o_div_dividend), 32'(ed));
    check_val("div_divisor", 32'(o_div_divisor), 32'(es));
    check_val("req_ready_issue", 32'(o_req_ready), 32'd0);
    step();
    if (exp_start) begin
      for (int i = 0; i < lat; i++) begin
        check_val("start_wait", 32'(o_div_start), 32'd0);
        check_val("rsp_valid_wait", 32'(o_rsp_valid), 32'd0);
        check_val("dividend_hold", 32'(o_div_dividend), 32'(ed));
        step();
      end
      i_div_done     = 1'b1;
      i_div_quotient = eq;
      step();
      i_div_done     = 1'b0;
      i_div_quotient = ~eq;
    end
    for (int d = 0; d < dly; d++) begin
      i_rsp_ready = 1'b0;
      #1;
      check_val("rsp_valid_hold", 32'(o_rsp_valid), 32'd1);
      check_val("rsp_id_hold", 32'(o_rsp_id), 32'(g));
      check_val("rsp_quot_hold", 32'(o_rsp_quotient), 32'(eq));
      check_val("req_ready_resp", 32'(o_req_ready), 32'd0);
      check_val("start_resp", 32'(o_div_start), 32'd0);
      step();
    end
    i_rsp_ready = 1'b1;
    #1;
    check_val("rsp_valid", 32'(o_rsp_valid), 32'd1);
    check_val("rsp_id", 32'(o_rsp_id), 32'(g));
    check_val("rsp_quotient", 32'(o_rsp_quotient), 32'(eq));
    check_val("rsp_div_zero", 32'(o_rsp_div_zero), 32'(es == 0));
    step();
    i_rsp_ready = 1'b0;
    i_req_valid = '0;
    m_rr = (g + 1) % N;
    #1;
    check_val("rsp_valid_done", 32'(o_rsp_valid), 32'd0);
    check_val("busy_done", 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_reset_n = 1'b0; i_req_valid = '0; i_req_dividend = '0; i_req_divisor = '0;
    i_div_done = 1'b0; i_div_quotient = '0; i_rsp_ready = 1'b0;
    #2;
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_val("rst_div_dividend", 32'(o_div_dividend), 32'd0);
    check_val("rst_rsp_quotient", 32'(o_rsp_quotient), 32'd0);
    step(); step();
    i_reset_n = 1'b1;
    step();

    // Directed single request: 3.0 / 2.0 = 1.5 (8'h18).
    dvd[0] = 8'h30; dvs[0] = 8'h20; dvd[1] = 8'h11; dvs[1] = 8'h22;
    do_txn(2'b01, 8, 0);

    // Both requesters valid continuously: grants alternate.
    for (int t = 0; t < 8; t++) begin
      dvd[0] = DW'($urandom); dvs[0] = DW'($urandom_range(1, 255));
      dvd[1] = DW'($urandom); dvs[1] = DW'($urandom_range(1, 255));
      do_txn(2'b11, $urandom_range(1, 4), 0);
    end

    // Response backpressure for 5 cycles.
    dvd[1] = 8'h50; dvs[1] = 8'h10;
    do_txn(2'b10, 3, 5);

    // Zero divisor from requester 1.
    dvd[1] = 8'h40; dvs[1] = 8'h00;
    do_txn(2'b10, 4, 1);

    // Put the pointer at 1, then reset while a request from 1 is in WAIT.
    dvd[0] = 8'h12; dvs[0] = 8'h03;
    do_txn(2'b01, 2, 0);
    dvd[1] = 8'h44; dvs[1] = 8'h02;
    drive_ops();
    i_req_valid = 2'b10;
    step();
    i_req_valid = '0;
    step(); step();
    i_reset_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(o_busy), 32'd0);
    check_val("abort_div_divisor", 32'(o_div_divisor), 32'd0);
    check_val("abort_start", 32'(o_div_start), 32'd0);
    step();
    i_reset_n = 1'b1;
    m_rr = 0;
    i_div_done = 1'b1; i_div_quotient = 8'h5A;
    step();
    i_div_done = 1'b0;
    #1;
    check_val("late_done_rsp", 32'(o_rsp_valid), 32'd0);
    check_val("late_done_busy", 32'(o_busy), 32'd0);
    step();
    dvd[0] = 8'h20; dvs[0] = 8'h40; dvd[1] = 8'h33; dvs[1] = 8'h11;
    do_txn(2'b11, 3, 0);

    // Stray done pulse while idle.
    i_div_done = 1'b1; i_div_quotient = 8'hC3;
    step();
    i_div_done = 1'b0;
    #1;
    check_val("stray_busy", 32'(o_busy), 32'd0);
    check_val("stray_rsp_valid", 32'(o_rsp_valid), 32'd0);
    step();

    // Randomized traffic, including occasional zero divisors.
    for (int t = 0; t < 20; t++) begin
      dvd[0] = DW'($urandom);
      dvd[1] = DW'($urandom);
      dvs[0] = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
      dvs[1] = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
      do_txn(N'($urandom_range(1, 3)), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
